jtkcpu_ind: RTL and testbench
=============================

// Module: jtkcpu_ind
// PURPOSE
// - Indirect-address fetch stage; sits directly downstream of the indexed-address calculator.
// - Takes the computed effective address (EA) and its indirect flag.
// - Indirect: reads two bytes (high byte at EA, low byte at EA+1) over the 8-bit data bus
//   and forms the final operand address.
// - Direct: passes EA through with no bus activity.
// - Result goes to the operand-fetch sequencer.
// PARAMETERS
// - none
// PORTS
// - rst_n     in   1   asynchronous active-low reset
// - clk       in   1   single system clock
// - cen       in   1   clock enable; all state advances only when cen=1
// - start     in   1   request: latch ea/indirect and begin
// - abort     in   1   synchronous cancel (e.g. interrupt/flush); return to IDLE
// - ea        in  16   effective address from the indexed-address calculator
// - indirect  in   1   1 = fetch 16-bit pointer at ea
// - din       in   8   memory read data
// - bus_ok    in   1   memory ready; a read beat completes when rd & bus_ok & cen
// - addr      out 16   bus address while rd=1
// - rd        out  1   bus read strobe
// - busy      out  1   high from accepted start until done
// - done      out  1   one-cen-cycle pulse; eff_addr valid
// - eff_addr  out 16   final operand address, held until next done
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE; addr=0, rd=0, busy=0, done=0, eff_addr=0, hi byte=0.
// - States: IDLE, RDHI, RDLO, [DUMMY], FIN. All registers update on posedge clk gated by cen.
// - IDLE, start=1:
//   - latch ea into ptr; busy<=1.
//   - indirect=0: go to FIN.
//   - indirect=1: go to RDHI; addr<=ea; rd<=1.
// - RDHI: while !bus_ok, hold addr/rd (wait states unbounded).
//   - On bus_ok: hi<=din; addr<=ptr+1; go to RDLO.
// - RDLO: on bus_ok: eff_addr<={hi,din}; rd<=0; go to DUMMY if enabled, else FIN.
// - FIN:
//   - direct path: eff_addr<=ptr.
//   - done<=1 for exactly one cen cycle; busy<=0; go to IDLE.
// - Latency in cen cycles, zero wait states, no macro:
//   - direct: done 2 cycles after start.
//   - indirect: done 4 cycles after start.
// - Arithmetic: ptr+1 is 16-bit modulo; 16'hFFFF wraps to 16'h0000, no carry out.
// - start while busy: ignored; latched values unchanged.
// - start on the same cen cycle as done: ignored; must be re-asserted once busy=0.
// - abort: wins over start and bus_ok on the same cycle.
//   - clears rd, busy, done; state=IDLE.
//   - eff_addr keeps its last completed value.
// - cen=0: all outputs hold (including done; pulse width counts in cen cycles).
// - Reset mid-fetch: immediate return to IDLE, no done pulse.
// - rd is never high outside RDHI/RDLO; addr holds its last value when rd=0.
// CONFIGURATION
// - JTKCPU_IND_DUMMY_EN defined:
//   - DUMMY state inserted after RDLO on the indirect path: one idle bus cycle, rd=0.
//   - Indirect latency becomes 5 cen cycles.
//   - Direct path is unaffected.
// - Not defined: RDLO goes straight to FIN; DUMMY state not synthesised.
// TESTING
// - Direct: ea=16'h1234, indirect=0, start pulse -> rd stays 0; done 2 cen cycles later; eff_addr=16'h1234.
// - Indirect: ea=16'h2000, mem[2000]=8'hAB, mem[2001]=8'hCD, bus_ok=1 -> addr 2000 then 2001; done at cycle 4 (5 with JTKCPU_IND_DUMMY_EN); eff_addr=16'hABCD.
// - Wrap: ea=16'hFFFF, indirect=1, mem[FFFF]=8'h12, mem[0000]=8'h34 -> second read at 16'h0000; eff_addr=16'h1234.
// - Wait states: bus_ok low 3 cycles in RDHI -> addr/rd held; hi not captured until bus_ok; done delayed by 3 cycles.
// - Abort/reset: abort asserted in RDLO -> rd=0, busy=0, no done, eff_addr unchanged; rst_n low in RDHI -> all outputs 0 immediately.
// - Gating: start while busy, and cen low for 2 cycles mid-fetch -> second start ignored; state frozen while cen=0; single done pulse.

Source files
------------

// File: rtl/jtkcpu_ind.sv
// jtkcpu_ind: indirect-address fetch stage. It reads a 16-bit big-endian pointer at EA, or passes EA through unchanged.
// Optional macro JTKCPU_IND_DUMMY_EN inserts one idle bus cycle after the low-byte read.
`default_nettype none

module jtkcpu_ind (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        cen,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] ea,
  input  logic        indirect,
  input  logic [7:0]  din,
  input  logic        bus_ok,
  output logic [15:0] addr,
  output logic        rd,
  output logic        busy,
  output logic        done,
  output logic [15:0] eff_addr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RDHI  = 3'd1,
    RDLO  = 3'd2,
`ifdef JTKCPU_IND_DUMMY_EN
    DUMMY = 3'd3,
`endif
    FIN   = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] ptr_q;
  logic [15:0] addr_q;
  logic [15:0] eff_q;
  logic [7:0]  hi_q;
  logic        ind_q;
  logic        rd_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] ptr_inc_d;

  // Pointer low byte lives at ptr+1, modulo 2^16.
  assign ptr_inc_d = ptr_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 16'd0;
      addr_q  <= 16'd0;
      eff_q   <= 16'd0;
      hi_q    <= 8'd0;
      ind_q   <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (cen) begin
      if (abort) begin
        state_q <= IDLE;
        rd_q    <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            done_q <= 1'b0;
            // A start coinciding with the done pulse is dropped, not queued.
            if (start && !done_q) begin
              ptr_q  <= ea;
              ind_q  <= indirect;
              busy_q <= 1'b1;
              if (indirect) begin
                addr_q  <= ea;
                rd_q    <= 1'b1;
                state_q <= RDHI;
              end else begin
                state_q <= FIN;
              end
            end
          end
          RDHI: begin
            if (bus_ok) begin
              hi_q    <= din;
              addr_q  <= ptr_inc_d;
              state_q <= RDLO;
            end
          end
          RDLO: begin
            if (bus_ok) begin
              eff_q   <= {hi_q, din};
              rd_q    <= 1'b0;
`ifdef JTKCPU_IND_DUMMY_EN
              state_q <= DUMMY;
`else
              state_q <= FIN;
`endif
            end
          end
`ifdef JTKCPU_IND_DUMMY_EN
          DUMMY: begin
            state_q <= FIN;
          end
`endif
          FIN: begin
            if (!ind_q) eff_q <= ptr_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign addr     = addr_q;
  assign rd       = rd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign eff_addr = eff_q;

endmodule

`default_nettype wire

// File: tb/tb_jtkcpu_ind.sv
// tb_jtkcpu_ind: directed bench with a transaction-queue model of the indirect fetch stage.
`default_nettype none

module tb_jtkcpu_ind;

`ifdef JTKCPU_IND_DUMMY_EN
  localparam int LAT_IND = 5;
  localparam int TAIL    = 2;
`else
  localparam int LAT_IND = 4;
  localparam int TAIL    = 1;
`endif
  localparam int LAT_DIR = 2;

  logic        rst_n, clk, cen, start, abort, indirect, bus_ok;
  logic [15:0] ea;
  logic [7:0]  din;
  logic [15:0] addr, eff_addr;
  logic        rd, busy, done;

  logic [7:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  jtkcpu_ind dut (
    .rst_n(rst_n), .clk(clk), .cen(cen), .start(start), .abort(abort),
    .ea(ea), .indirect(indirect), .din(din), .bus_ok(bus_ok),
    .addr(addr), .rd(rd), .busy(busy), .done(done), .eff_addr(eff_addr)
  );

  // Garbage on the bus while not ready, so an early capture is visible.
  assign din = bus_ok ? mem[addr] : 8'hEE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending bus reads as a queue of addresses, then a countdown to done.
  logic [15:0] m_q[$];
  int          m_tail;
  logic        m_busy, m_done, m_ind;
  logic [15:0] m_eff, m_ptr, m_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_tail = 0; m_busy = 0; m_done = 0; m_ind = 0;
      m_eff = 16'd0; m_ptr = 16'd0; m_val = 16'd0;
    end else if (cen) begin
      if (abort) begin
        m_q.delete();
        m_tail = 0; m_busy = 0; m_done = 0;
      end else if (!m_busy) begin
        if (m_done) m_done = 0;
        else if (start) begin
          m_busy = 1; m_ptr = ea; m_ind = indirect; m_val = 16'd0;
          if (indirect) begin
            m_q.push_back(ea);
            m_q.push_back(ea + 16'd1);
            m_tail = TAIL;
          end else begin
            m_tail = 1;
          end
        end
      end else if (m_q.size() != 0) begin
        if (bus_ok) begin
          m_val = {m_val[7:0], mem[m_q[0]]};
          m_q.delete(0);
          if (m_q.size() == 0) m_eff = m_val;
        end
      end else begin
        m_tail--;
        if (m_tail == 0) begin
          m_busy = 0; m_done = 1;
          if (!m_ind) m_eff = m_ptr;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("rd",   {15'd0, rd},   {15'd0, (m_q.size() != 0)});
      chk("busy", {15'd0, busy}, {15'd0, m_busy});
      chk("done", {15'd0, done}, {15'd0, m_done});
      chk("eff_addr", eff_addr, m_eff);
      if (m_q.size() != 0) chk("addr", addr, m_q[0]);
    end
  end

  task automatic run_txn(input string nm, input logic [15:0] a, input logic ind, input int waits,
                         input int exp_lat, input int exp_rdcyc, input logic [15:0] exp_last_addr,
                         input logic [15:0] exp_eff);
    int lat = 0;
    int rdcyc = 0;
    logic [15:0] last_a = 16'hDEAD;
    @(negedge clk);
    start = 1; ea = a; indirect = ind; bus_ok = (waits == 0);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      start = 0;
      if (k == waits + 1) bus_ok = 1;
      if (rd) begin rdcyc++; last_a = addr; end
      if (done) lat = k;
    end
    if (lat == 0) begin
      errors++; checks++;
      $display("FAIL %s timeout: no done within 40 cycles", nm);
    end else begin
      chk_int({nm, " latency"}, lat, exp_lat);
      chk({nm, " eff_addr"}, eff_addr, exp_eff);
    end
    chk_int({nm, " rd cycles"}, rdcyc, exp_rdcyc);
    if (exp_rdcyc != 0) chk({nm, " last addr"}, last_a, exp_last_addr);
  endtask

  initial begin
    int dones;
    int lat;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h2000] = 8'hAB; mem[16'h2001] = 8'hCD;
    mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
    mem[16'h4000] = 8'h5A; mem[16'h4001] = 8'hC3;
    mem[16'h3000] = 8'h77; mem[16'h3001] = 8'h88;
    rst_n = 0; cen = 1; start = 0; abort = 0; ea = 16'd0; indirect = 0; bus_ok = 1;
    repeat (2) @(negedge clk);
    chk("reset addr", addr, 16'h0000);
    chk("reset rd", {15'd0, rd}, 16'd0);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset done", {15'd0, done}, 16'd0);
    chk("reset eff", eff_addr, 16'h0000);
    rst_n = 1;
    repeat (2) @(negedge clk);

    run_txn("direct",   16'h1234, 1'b0, 0, LAT_DIR,     0, 16'h0000, 16'h1234);
    run_txn("indirect", 16'h2000, 1'b1, 0, LAT_IND,     2, 16'h2001, 16'hABCD);
    run_txn("wrap",     16'hFFFF, 1'b1, 0, LAT_IND,     2, 16'h0000, 16'h1234);
    run_txn("waits",    16'h4000, 1'b1, 3, LAT_IND + 3, 5, 16'h4001, 16'h5AC3);
    repeat (2) @(negedge clk);

    // Abort while in the low-byte read; bus_ok is high on the same cycle.
    start = 1; ea = 16'h3000; indirect = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("abort pre rd", {15'd0, rd}, 16'd1);
    chk("abort pre addr", addr, 16'h3001);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("abort rd", {15'd0, rd}, 16'd0);
    chk("abort busy", {15'd0, busy}, 16'd0);
    chk("abort eff", eff_addr, 16'h5AC3);
    dones = 0;
    repeat (6) begin @(negedge clk); if (done) dones++; end
    chk_int("abort no done", dones, 0);

    // Asynchronous reset in the high-byte read.
    start = 1; ea = 16'h2000; indirect = 1;
    @(negedge clk); start = 0;
    chk("prereset rd", {15'd0, rd}, 16'd1);
    rst_n = 0;
    #1;
    chk("midreset addr", addr, 16'h0000);
    chk("midreset rd", {15'd0, rd}, 16'd0);
    chk("midreset busy", {15'd0, busy}, 16'd0);
    chk("midreset eff", eff_addr, 16'h0000);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // Start while busy, cen low for two cycles, and a start on the done cycle.
    start = 1; ea = 16'h2000; indirect = 1;
    @(negedge clk); ea = 16'h1111; indirect = 0;
    @(negedge clk); start = 0; cen = 0;
    @(negedge clk);
    @(negedge clk); cen = 1;
    dones = 0; lat = 0;
    for (int k = 4; k <= 20; k++) begin
      if (done) begin
        dones++;
        if (lat == 0) begin lat = k; start = 1; ea = 16'h1111; indirect = 0; end
      end
      @(negedge clk);
      start = 0;
      if (lat != 0 && k == lat) chk("after done busy", {15'd0, busy}, 16'd0);
    end
    chk_int("gate latency", lat, LAT_IND + 2);
    chk_int("gate done count", dones, 1);
    chk("gate eff", eff_addr, 16'hABCD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
